bch_syndrome_p32: RTL and testbench

// - First stage of the BCH(8191,8087) t=8 decoder over GF(2^13), ahead of the Euclidean key-equation solver.
// - Takes the received codeword 32 bits per clock and computes the 16 syndromes S_j = R(alpha^j), j=1..16.
// - After 256 words, S1..S16 are valid and held for the key-equation stage.

---
 rtl/bch_pkg.sv | 64 ++++++
 rtl/bch_syndrome_p32_if.sv | 23 ++
 rtl/bch_syn_acc.sv | 46 ++++
 rtl/bch_syndrome_p32.sv | 71 +++++++
 tb/tb_bch_syndrome_p32.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bch_pkg.sv
// GF(2^13) constants and constant-multiply helpers for the BCH(8191,8087) syndrome stage.
// Pure functions only; no latency and no flow control.
package bch_pkg;

  localparam int M     = 13;
  localparam int N     = 8191;
  localparam int P     = 32;
  localparam int T     = 8;
  localparam int WORDS = 256;
  localparam logic [M-1:0] POLY = 13'h001B;

  function automatic logic [M-1:0] gf_mul_alpha(input logic [M-1:0] a);
    logic [M-1:0] sh;
    sh = {a[M-2:0], 1'b0};
    return a[M-1] ? (sh ^ POLY) : sh;
  endfunction

  function automatic logic [M-1:0] gf_alpha_pow(input int exp);
    logic [M-1:0] v;
    int e;
    e = exp % N;
    if (e < 0) e = e + N;
    v = 1;
    for (int i = 0; i < e; i++) v = gf_mul_alpha(v);
    return v;
  endfunction

  // Column b holds alpha^(exp+b), so multiplying this matrix by a gives a*alpha^exp.
  function automatic logic [M*M-1:0] gf_const_mat(input int exp);
    logic [M*M-1:0] mat;
    logic [M-1:0]   v;
    v = gf_alpha_pow(exp);
    for (int b = 0; b < M; b++) begin
      mat[b*M +: M] = v;
      v = gf_mul_alpha(v);
    end
    return mat;
  endfunction

  function automatic logic [M-1:0] gf_mat_mul(input logic [M*M-1:0] mat, input logic [M-1:0] a);
    logic [M-1:0] res;
    res = '0;
    for (int b = 0; b < M; b++) begin
      if (a[b]) res = res ^ mat[b*M +: M];
    end
    return res;
  endfunction

  function automatic logic [M-1:0] gf_mul_const(input logic [M-1:0] a, input int exp);
    return gf_mat_mul(gf_const_mat(exp), a);
  endfunction

  // Squaring spreads bit b to degree 2b, then reduces degrees 24..13 by p(x).
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] t;
    t = '0;
    for (int b = 0; b < M; b++) t[2*b] = a[b];
    for (int d = 2*M-2; d >= M; d--) begin
      if (t[d]) t[d -: M+1] = t[d -: M+1] ^ {1'b1, POLY};
    end
    return t[M-1:0];
  endfunction

endpackage

// File: rtl/bch_syndrome_p32_if.sv
// Received-bit lanes into the syndrome stage and the 16 syndromes out of it.
// Plain wires, no handshake: one 32-bit word per clock, outputs held after the last word.
interface bch_syndrome_p32_if;
  import bch_pkg::*;

  logic r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,  r8,  r9,  r10, r11, r12, r13, r14, r15;
  logic r16, r17, r18, r19, r20, r21, r22, r23, r24, r25, r26, r27, r28, r29, r30, r31;
  logic [M-1:0] S1, S2,  S3,  S4,  S5,  S6,  S7,  S8;
  logic [M-1:0] S9, S10, S11, S12, S13, S14, S15, S16;

  modport master (
    output r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,  r8,  r9,  r10, r11, r12, r13, r14, r15,
           r16, r17, r18, r19, r20, r21, r22, r23, r24, r25, r26, r27, r28, r29, r30, r31,
    input  S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13, S14, S15, S16
  );

  modport slave (
    input  r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,  r8,  r9,  r10, r11, r12, r13, r14, r15,
           r16, r17, r18, r19, r20, r21, r22, r23, r24, r25, r26, r27, r28, r29, r30, r31,
    output S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13, S14, S15, S16
  );

endinterface

// File: rtl/bch_syn_acc.sv
// One odd-syndrome Horner accumulator: A <= A*alpha^(P*J) ^ sum_k r_k*alpha^(J*k).
// One word per clock when en is high; holds when en is low; no backpressure.
module bch_syn_acc #(
  parameter int J = 1,
  parameter int P = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [P-1:0]        r,
  output logic [bch_pkg::M-1:0] acc
);
  import bch_pkg::*;

  function automatic logic [P*M-1:0] in_vecs();
    logic [P*M-1:0] t;
    logic [M-1:0]   v;
    v = 1;
    for (int k = 0; k < P; k++) begin
      t[k*M +: M] = v;
      v = gf_mul_const(v, J);
    end
    return t;
  endfunction

  localparam logic [P*M-1:0] IN_VECS = in_vecs();
  localparam logic [M*M-1:0] FB_MAT  = gf_const_mat(P * J);

  logic [M-1:0] acc_q, acc_d, in_sum;

  always_comb begin
    in_sum = '0;
    for (int k = 0; k < P; k++) begin
      if (r[k]) in_sum = in_sum ^ IN_VECS[k*M +: M];
    end
    acc_d = en ? (gf_mat_mul(FB_MAT, acc_q) ^ in_sum) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/bch_syndrome_p32.sv
// BCH(8191,8087) t=8 syndrome stage: 256 words of 32 bits in, S1..S16 final after the 256th word.
// No handshake; accumulators freeze after word 255 until the next reset.
module bch_syndrome_p32 import bch_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  bch_syndrome_p32_if.slave bus
);

  logic [8:0]   cnt_q, cnt_d;
  logic         run;
  logic [P-1:0] r_vec;
  logic [M-1:0] s_odd [T];
  logic [M-1:0] s2, s4, s6, s8, s10, s12, s14, s16;

  // The source keeps driving after the last word, so counting stops at WORDS.
  always_comb begin
    run   = (cnt_q != 9'(WORDS));
    cnt_d = run ? (cnt_q + 9'd1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign r_vec = {bus.r31, bus.r30, bus.r29, bus.r28, bus.r27, bus.r26, bus.r25, bus.r24,
                  bus.r23, bus.r22, bus.r21, bus.r20, bus.r19, bus.r18, bus.r17, bus.r16,
                  bus.r15, bus.r14, bus.r13, bus.r12, bus.r11, bus.r10, bus.r9,  bus.r8,
                  bus.r7,  bus.r6,  bus.r5,  bus.r4,  bus.r3,  bus.r2,  bus.r1,  bus.r0};

  for (genvar g = 0; g < T; g++) begin : g_acc
    bch_syn_acc #(
      .J (2*g + 1),
      .P (P)
    ) u_acc (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .r     (r_vec),
      .acc   (s_odd[g])
    );
  end

  // Even syndromes are squares of lower ones: S_2j = S_j^2.
  assign s2  = gf_sq(s_odd[0]);
  assign s4  = gf_sq(s2);
  assign s6  = gf_sq(s_odd[1]);
  assign s8  = gf_sq(s4);
  assign s10 = gf_sq(s_odd[2]);
  assign s12 = gf_sq(s6);
  assign s14 = gf_sq(s_odd[3]);
  assign s16 = gf_sq(s8);

  assign bus.S1  = s_odd[0];
  assign bus.S2  = s2;
  assign bus.S3  = s_odd[1];
  assign bus.S4  = s4;
  assign bus.S5  = s_odd[2];
  assign bus.S6  = s6;
  assign bus.S7  = s_odd[3];
  assign bus.S8  = s8;
  assign bus.S9  = s_odd[4];
  assign bus.S10 = s10;
  assign bus.S11 = s_odd[5];
  assign bus.S12 = s12;
  assign bus.S13 = s_odd[6];
  assign bus.S14 = s14;
  assign bus.S15 = s_odd[7];
  assign bus.S16 = s16;

endmodule

// File: tb/tb_bch_syndrome_p32.sv
// Scoreboard bench for bch_syndrome_p32: syndromes of each stream are evaluated directly as
// R(alpha^j) from an antilog table and checked when the stream's word count is reached.
module tb_bch_syndrome_p32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bch_syndrome_p32_if bus();

  bch_syndrome_p32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [16*13-1:0] syn;
    logic [31:0]      at;
  } exp_entry_t;

  exp_entry_t sb_q[$];
  string      tag_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = -1;

  int alog [8191];
  int glog [8192];
  bit cw      [8191];
  bit cw_keep [8191];
  bit gen     [105];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(glog[a] + glog[b]) % 8191];
  endfunction

  function automatic void build_tables();
    int v;
    v = 1;
    for (int e = 0; e < 8191; e++) begin
      alog[e] = v;
      glog[v] = e;
      v = v << 1;
      if ((v & 'h2000) != 0) v = v ^ 'h201B;
    end
  endfunction

  // g(x) = product of the minimal polynomials of alpha^1, alpha^3, ..., alpha^15.
  function automatic void build_generator();
    int mp [14];
    int nm [14];
    bit tmp [105];
    int gdeg;
    int root;
    gen = '{default: 1'b0};
    gen[0] = 1'b1;
    gdeg = 0;
    for (int j = 1; j < 16; j += 2) begin
      mp = '{default: 0};
      mp[0] = 1;
      for (int i = 0; i < 13; i++) begin
        root = alog[(j * (1 << i)) % 8191];
        nm[0] = gmul(mp[0], root);
        for (int d = 1; d < 14; d++) nm[d] = mp[d-1] ^ gmul(mp[d], root);
        mp = nm;
      end
      tmp = '{default: 1'b0};
      for (int a = 0; a <= gdeg; a++)
        if (gen[a])
          for (int b = 0; b < 14; b++)
            if (mp[b] != 0) tmp[a+b] = ~tmp[a+b];
      gen = tmp;
      gdeg = gdeg + 13;
    end
  endfunction

  function automatic logic [16*13-1:0] model_syn();
    logic [16*13-1:0] s;
    s = '0;
    for (int d = 0; d < 8191; d++)
      if (cw[d])
        for (int j = 1; j <= 16; j++)
          s[(j-1)*13 +: 13] = s[(j-1)*13 +: 13] ^ 13'(alog[(j * d) % 8191]);
    return s;
  endfunction

  // Word w lane k carries the coefficient of x^(8160-32w+k); x^8191 is the framing zero.
  function automatic logic [31:0] word_of(input int w);
    logic [31:0] v;
    int d;
    for (int k = 0; k < 32; k++) begin
      d = 8160 - 32*w + k;
      v[k] = (d <= 8190) ? cw[d] : 1'b0;
    end
    return v;
  endfunction

  task automatic drive_r(input logic [31:0] v);
    {bus.r31, bus.r30, bus.r29, bus.r28, bus.r27, bus.r26, bus.r25, bus.r24,
     bus.r23, bus.r22, bus.r21, bus.r20, bus.r19, bus.r18, bus.r17, bus.r16,
     bus.r15, bus.r14, bus.r13, bus.r12, bus.r11, bus.r10, bus.r9,  bus.r8,
     bus.r7,  bus.r6,  bus.r5,  bus.r4,  bus.r3,  bus.r2,  bus.r1,  bus.r0} = v;
  endtask

  task automatic push(input logic [16*13-1:0] s, input int at, input string tag);
    exp_entry_t e;
    e.syn = s;
    e.at  = 32'(at);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run_stream(input string tag, input int abort_word, input bit toggle);
    logic [16*13-1:0] s;
    s = model_syn();
    push('0, 0, {tag, "/rst"});
    if (abort_word < 0) begin
      push(s, 256, {tag, "/done"});
      push(s, 356, {tag, "/hold"});
    end
    @(negedge clk);
    reset = 1'b0;
    drive_r(32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int w = 0; w < 256 && (abort_word < 0 || w < abort_word); w++) begin
      drive_r(word_of(w));
      @(negedge clk);
    end
    if (abort_word < 0)
      for (int c = 0; c < 110; c++) begin
        drive_r(toggle ? $urandom : 32'h0);
        @(negedge clk);
      end
  endtask

  always @(posedge clk) begin
    if (reset === 1'b0)  cyc = 0;
    else if (cyc >= 0)   cyc = cyc + 1;
  end

  always @(negedge clk) begin : monitor
    exp_entry_t       e;
    string            t;
    logic [16*13-1:0] got;
    if (sb_q.size() > 0 && cyc == int'(sb_q[0].at)) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      got = {bus.S16, bus.S15, bus.S14, bus.S13, bus.S12, bus.S11, bus.S10, bus.S9,
             bus.S8,  bus.S7,  bus.S6,  bus.S5,  bus.S4,  bus.S3,  bus.S2,  bus.S1};
      for (int j = 1; j <= 16; j++) begin
        vectors = vectors + 1;
        if (got[(j-1)*13 +: 13] !== e.syn[(j-1)*13 +: 13]) begin
          miscompares = miscompares + 1;
          $display("FAIL %s S%0d got %h expected %h", t, j,
                   got[(j-1)*13 +: 13], e.syn[(j-1)*13 +: 13]);
        end
      end
    end
  end

  initial begin
    int nerr;
    reset = 1'b0;
    drive_r(32'h0);
    build_tables();
    build_generator();

    cw = '{default: 1'b0};
    run_stream("zero", -1, 1'b0);

    cw = '{default: 1'b0}; cw[0] = 1'b1;
    run_stream("err_x0", -1, 1'b1);

    cw = '{default: 1'b0}; cw[1] = 1'b1;
    run_stream("err_x1", -1, 1'b1);

    cw = '{default: 1'b0}; cw[8190] = 1'b1;
    run_stream("err_x8190", -1, 1'b1);

    cw = '{default: 1'b0};
    for (int a = 0; a < 8087; a++)
      if ($urandom_range(0, 1) == 1)
        for (int b = 0; b < 105; b++)
          if (gen[b]) cw[a+b] = ~cw[a+b];
    cw_keep = cw;
    run_stream("codeword", -1, 1'b1);

    cw = cw_keep; cw[0] = ~cw[0]; cw[1] = ~cw[1];
    run_stream("codeword_err01", -1, 1'b1);

    for (int d = 0; d < 8191; d++) cw[d] = 1'($urandom_range(0, 1));
    run_stream("abort", 100, 1'b1);
    cw = '{default: 1'b0}; cw[0] = 1'b1;
    run_stream("after_abort", -1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      cw = cw_keep;
      nerr = int'($urandom_range(1, 8));
      for (int e = 0; e < nerr; e++) begin
        int pos;
        pos = int'($urandom_range(0, 8190));
        cw[pos] = ~cw[pos];
      end
      run_stream($sformatf("rand_err%0d", n), -1, 1'b1);
    end

    for (int n = 0; n < 2; n++) begin
      for (int d = 0; d < 8191; d++) cw[d] = 1'($urandom_range(0, 1));
      run_stream($sformatf("rand_bits%0d", n), -1, 1'b1);
    end

    repeat (5) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard pending got %0d entries expected 0", sb_q.size());
      miscompares = miscompares + sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
